// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: request, stimulus and result signals between the scanner and its user.
interface truth_table_scanner_if #(
    parameter int N_VARS = 3,
    parameter int TBL_W  = 2 ** N_VARS
);
    logic              start;
    logic [3:0]        letra_in;
    logic [TBL_W-1:0]  expect_in;
    logic              s_in;
    logic [N_VARS-1:0] vars;
    logic [3:0]        letra;
    logic              busy;
    logic              done;
    logic [TBL_W-1:0]  table_out;
    logic [N_VARS:0]   ones_count;
    logic              letra_ok;
    logic              pass;

    modport master (
        output start, letra_in, expect_in, s_in,
        input  vars, letra, busy, done, table_out, ones_count, letra_ok, pass
    );

    modport slave (
        input  start, letra_in, expect_in, s_in,
        output vars, letra, busy, done, table_out, ones_count, letra_ok, pass
    );
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks the function inputs through every combination, waits SETTLE
// cycles per step, samples s_in and reports the table, its popcount and a compare result.
module truth_table_scanner #(
    parameter int N_VARS = 3,
    parameter int SETTLE = 1
) (
    input logic                  clk,
    input logic                  reset,
    truth_table_scanner_if.slave bus
);
    localparam int TBL_W = 2 ** N_VARS;
    localparam int CW    = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int PW    = N_VARS + 1;

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_VARS-1:0] idx;
    logic [CW-1:0]     cnt;
    logic [TBL_W-1:0]  shadow, shadow_nxt, expected;
    logic [PW-1:0]     pop;
    logic              last;

    assign last = idx == N_VARS'(TBL_W - 1);

    always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? WAIT : IDLE;
            WAIT:    state_nxt = cnt == '0 ? SAMPLE : WAIT;
            SAMPLE:  state_nxt = last ? DONE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // The table including the sample being taken now, so results land with the done pulse.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[idx] = bus.s_in;
        pop             = '0;
        for (int i = 0; i < TBL_W; i++) pop = pop + PW'(shadow_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.vars       <= '0;
            bus.letra      <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.table_out  <= '0;
            bus.ones_count <= '0;
            bus.letra_ok   <= 1'b0;
            bus.pass       <= 1'b0;
            idx            <= '0;
            cnt            <= '0;
            shadow         <= '0;
            expected       <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.letra <= bus.letra_in;
                    expected  <= bus.expect_in;
                    bus.vars  <= '0;
                    idx       <= '0;
                    cnt       <= CW'(SETTLE - 1);
                    bus.busy  <= 1'b1;
                end
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                SAMPLE: begin
                    shadow <= shadow_nxt;
                    if (last) begin
                        bus.table_out  <= shadow_nxt;
                        bus.ones_count <= pop;
                        bus.letra_ok   <= bus.letra >= 4'hA && bus.letra <= 4'hE;
                        bus.pass       <= shadow_nxt == expected;
                        bus.done       <= 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        bus.vars <= idx + 1'b1;
                        cnt      <= CW'(SETTLE - 1);
                    end
                end
                default: bus.busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed scans; expected results are queued at start and a
// monitor checks them whenever done pulses, including the cycle the result arrives.
module tb_truth_table_scanner;
    localparam int N  = 3;
    localparam int TW = 1 << N;

    typedef struct {
        logic [7:0] tbl;
        logic [3:0] ones;
        logic       ok;
        logic       ps;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    logic d1 = 1'b0, d2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_scanner_if #(.N_VARS(N)) b1 ();
    truth_table_scanner_if #(.N_VARS(N)) b3 ();

    truth_table_scanner #(.N_VARS(N), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    truth_table_scanner #(.N_VARS(N), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    // Function under test: x&(y|z) for selectors A..E, constant 0 otherwise.
    function automatic logic f(logic [3:0] l, logic [2:0] v);
        return (l >= 4'hA && l <= 4'hE) && v[2] && (v[1] || v[0]);
    endfunction

    assign b1.s_in = f(b1.letra, b1.vars);
    always @(posedge clk) begin
        d1 <= f(b3.letra, b3.vars);
        d2 <= d1;
    end
    assign b3.s_in = d2;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic score(string tag, exp_t e, logic [7:0] t, logic [3:0] o, logic k, logic p);
        chk({tag, "_cycle"}, cyc, e.at);
        chk({tag, "_table"}, t, e.tbl);
        chk({tag, "_ones"}, o, e.ones);
        chk({tag, "_letra_ok"}, k, e.ok);
        chk({tag, "_pass"}, p, e.ps);
    endtask

    always @(negedge clk) if (b1.done === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL done1_unexpected: done=1 at cycle %0d, expected done=0", cyc);
        end else begin
            e1 = q1.pop_front();
            score("s1", e1, b1.table_out, b1.ones_count, b1.letra_ok, b1.pass);
        end
    end

    always @(negedge clk) if (b3.done === 1'b1) begin
        checks++;
        if (q3.size() == 0) begin
            errors++;
            $display("FAIL done3_unexpected: done=1 at cycle %0d, expected done=0", cyc);
        end else begin
            e3 = q3.pop_front();
            score("s3", e3, b3.table_out, b3.ones_count, b3.letra_ok, b3.pass);
        end
    end

    task automatic scan1(logic [3:0] l, logic [7:0] ex, logic [7:0] tbl, logic [3:0] ones,
                         logic ok, logic ps);
        @(negedge clk);
        b1.start = 1'b1; b1.letra_in = l; b1.expect_in = ex;
        @(negedge clk);
        b1.start = 1'b0; b1.letra_in = 4'h0; b1.expect_in = ~ex;
        chk("busy_after_accept", b1.busy, 1);
        q1.push_back('{tbl: tbl, ones: ones, ok: ok, ps: ps, at: cyc + TW * 2});
    endtask

    task automatic wait_done(bit three, int budget);
        int n = 0;
        while ((three ? q3.size() : q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((three ? q3.size() : q1.size()) != 0) begin
            errors++;
            $display("FAIL done_timeout: result still pending after %0d cycles, expected none", budget);
            if (three) q3.delete(); else q1.delete();
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_vars"}, b1.vars, 0);
        chk({tag, "_letra"}, b1.letra, 0);
        chk({tag, "_busy"}, b1.busy, 0);
        chk({tag, "_done"}, b1.done, 0);
        chk({tag, "_table"}, b1.table_out, 0);
        chk({tag, "_ones"}, b1.ones_count, 0);
        chk({tag, "_letra_ok"}, b1.letra_ok, 0);
        chk({tag, "_pass"}, b1.pass, 0);
    endtask

    initial begin
        logic [7:0] prev;
        reset = 1'b1;
        b1.start = 1'b1; b1.letra_in = 4'hA; b1.expect_in = 8'hE0;
        b3.start = 1'b0; b3.letra_in = 4'h0; b3.expect_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        b1.start = 1'b0;
        check_zero("reset");

        // First scan: vars steps 0..7, each value held two cycles, busy throughout.
        scan1(4'hA, 8'hE0, 8'hE0, 4'd3, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("vars_step", b1.vars, k / 2);
            chk("busy_scan", b1.busy, 1);
            @(negedge clk);
        end
        wait_done(0, 10);
        repeat (3) @(negedge clk);
        chk("vars_hold", b1.vars, 7);
        chk("busy_idle", b1.busy, 0);
        chk("table_hold", b1.table_out, 8'hE0);

        // Unsupported selector; previous result must hold mid-scan.
        scan1(4'h9, 8'hE0, 8'h00, 4'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("hold_mid_scan", b1.table_out, 8'hE0);
        wait_done(0, 20);

        // Selector just above the range with a matching expectation.
        scan1(4'hF, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1);
        wait_done(0, 20);

        prev = 8'h00;
        for (int l = 4'hA; l <= 4'hE; l++) begin
            scan1(4'(l), 8'hE0, 8'hE0, 4'd3, 1'b1, 1'b1);
            repeat (8) @(negedge clk);
            chk("sweep_hold", b1.table_out, prev);
            wait_done(0, 20);
            prev = 8'hE0;
        end

        // Starts during an active scan are ignored and not queued.
        scan1(4'hB, 8'hE0, 8'hE0, 4'd3, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            b1.start = k == 3 || k == 10;
            b1.letra_in = 4'h9;
            chk("busy_no_drop", b1.busy, 1);
        end
        b1.start = 1'b0;
        wait_done(0, 10);
        repeat (20) @(negedge clk);

        // Reset in the middle of a scan discards it.
        scan1(4'hC, 8'hE0, 8'hE0, 4'd3, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        check_zero("mid_reset_idle");
        scan1(4'hA, 8'hE0, 8'hE0, 4'd3, 1'b1, 1'b1);
        wait_done(0, 20);

        // Longer settle against a function with a two-cycle output delay.
        @(negedge clk);
        b3.start = 1'b1; b3.letra_in = 4'hD; b3.expect_in = 8'hE0;
        @(negedge clk);
        b3.start = 1'b0; b3.letra_in = 4'h0; b3.expect_in = 8'h00;
        chk("s3_busy", b3.busy, 1);
        q3.push_back('{tbl: 8'hE0, ones: 4'd3, ok: 1'b1, ps: 1'b1, at: cyc + TW * 4});
        wait_done(1, 40);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
